// File: rtl/shift_chain_pkg.sv
// ============================================================================
// Module   : shift_chain_pkg
// Purpose  : Shared state encoding and default chain depth for chain sequencers.
// Revision : 1.0
// ============================================================================
`default_nettype none

package shift_chain_pkg;
  localparam int DEFAULT_LENGTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2,
    CLEAR = 2'd3
  } state_t;
endpackage

`default_nettype wire

// File: rtl/shift_bit_cnt.sv
// ============================================================================
// Module   : shift_bit_cnt
// Purpose  : Modulo-LENGTH bit counter with clear, enable and terminal count.
// Revision : 1.0
// ============================================================================
`default_nettype none

module shift_bit_cnt #(
  parameter int LENGTH = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);
  localparam int CNT_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(LENGTH - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = (cnt_q == C_LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_tc = (cnt_q == C_LAST);
endmodule

`default_nettype wire

// File: rtl/shift_chain_ctrl.sv
// ============================================================================
// Module   : shift_chain_ctrl
// Purpose  : Shifts a parallel word MSB-first into a serial chain and returns
//            the displaced previous contents; also issues chain-clear pulses.
// Revision : 1.0
// ============================================================================
`default_nettype none

module shift_chain_ctrl
  import shift_chain_pkg::*;
#(
  parameter int LENGTH = DEFAULT_LENGTH
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_valid,
  input  logic [LENGTH-1:0] i_wr_data,
  output logic              o_wr_ready,
  output logic              o_rd_valid,
  output logic [LENGTH-1:0] o_rd_data,
  input  logic              i_rd_ready,
  input  logic              i_clr,
  output logic              o_sr_en,
  output logic              o_sr_din,
  input  logic              i_sr_dout,
  output logic              o_sr_clr
);
  state_t            state_q, state_d;
  logic [LENGTH-1:0] word_q, word_d;
  logic [LENGTH-1:0] cap_q, cap_d;
  logic              sr_en_q, sr_en_d;
  logic              sr_din_q, sr_din_d;
  logic              sr_clr_q, sr_clr_d;
  logic              rd_valid_q, rd_valid_d;
  logic [LENGTH-1:0] rd_data_q, rd_data_d;
  logic              cnt_tc;

  shift_bit_cnt #(
    .LENGTH(LENGTH)
  ) u_bit_cnt (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_clr(state_q == IDLE),
    .i_en (state_q == SHIFT),
    .o_tc (cnt_tc)
  );

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    cap_d   = cap_q;
    unique case (state_q)
      IDLE: begin
        if (i_clr) begin
          state_d = CLEAR;
        end else if (i_wr_valid) begin
          state_d = SHIFT;
          word_d  = i_wr_data;
        end
      end
      SHIFT: begin
        // Rotating keeps the outgoing bit at the MSB and restores the word after LENGTH shifts.
        word_d = {word_q[LENGTH-2:0], word_q[LENGTH-1]};
        cap_d  = {cap_q[LENGTH-2:0], i_sr_dout};
        if (cnt_tc) state_d = DONE;
      end
      DONE: begin
        if (i_rd_ready) state_d = IDLE;
      end
      CLEAR: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are computed from next-state values so they can be registered without lag.
    sr_en_d    = (state_d == SHIFT);
    sr_din_d   = (state_d == SHIFT) && word_d[LENGTH-1];
    sr_clr_d   = (state_d == CLEAR);
    rd_valid_d = (state_d == DONE);
    rd_data_d  = rd_valid_d ? cap_d : '0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      word_q     <= '0;
      cap_q      <= '0;
      sr_en_q    <= 1'b0;
      sr_din_q   <= 1'b0;
      sr_clr_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      cap_q      <= cap_d;
      sr_en_q    <= sr_en_d;
      sr_din_q   <= sr_din_d;
      sr_clr_q   <= sr_clr_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign o_wr_ready = (state_q == IDLE) && !i_clr;
  assign o_rd_valid = rd_valid_q;
  assign o_rd_data  = rd_data_q;
  assign o_sr_en    = sr_en_q;
  assign o_sr_din   = sr_din_q;
  assign o_sr_clr   = sr_clr_q;
endmodule

`default_nettype wire
